bus_timer: RTL
==============

# bus_timer

Memory-mapped machine timer that sits on the core's APB-like bus, downstream of the bus access unit. It holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp` and a prescaler, and serves single-wait-state reads and writes. It drives the core's `irqTimer` input whenever `mtime >= mtimecmp`. Its `ready`/`rdata` outputs are OR-combined with the other bus slaves by the interconnect.

## Interface
- `BaseAddr`, default 32'h4000_0000: base of the 256-byte register window; must be 256-byte aligned.
- `clk`  input  1: clock; all state changes on the rising edge.
- `rst`  input  1: reset, asynchronous, active-high.
- `addr`  input  32: byte address from the core.
- `select`  input  1: transfer in progress (setup and access phase).
- `enable`  input  1: access phase.
- `write`  input  1: 1 = write, 0 = read.
- `wdata`  input  32: write data.
- `rdata`  output  32: read data; 0 whenever `ready`=0 or the transfer was a write.
- `ready`  output  1: transfer complete; asserted for exactly one cycle per accepted transfer.
- `irqTimer`  output  1: timer interrupt request, level.

## Operation
- Hit means `addr[31:8] == BaseAddr[31:8]`. Word offset is `addr[7:2]`, and `addr[1:0]` is ignored. Non-hit transfers are ignored completely: `ready` and `rdata` stay 0.
- Register map:
  - 0x00 MTIME_LO: R/W.
  - 0x04 MTIME_HI: write sets `mtime[63:32]`. Read returns the SHADOW_HI value.
  - 0x08 MTIMECMP_LO: R/W.
  - 0x0C MTIMECMP_HI: R/W.
  - 0x10 CTRL: bit0 EN; bits[15:8] PRESCALE; other bits read 0.
  - 0x14 MTIME_HI_LIVE: read-only live `mtime[63:32]`.
  - Other offsets: read 0, writes ignored, `ready` still given.
- Reading MTIME_LO also loads `mtime[63:32]` into SHADOW_HI in the same cycle. Software reads LO then HI and gets an atomic 64-bit pair.
- Reset values: `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, SHADOW_HI=0, EN=1, PRESCALE=0, prescale counter=0, `ready`=0, `rdata`=0, `irqTimer`=0.
- Tick generation:
  - When EN=1, the prescale counter increments every cycle.
  - When the counter equals PRESCALE, it clears to 0 and `mtime` increments by 1. A tick therefore occurs every PRESCALE+1 cycles.
  - `mtime` wraps from 2^64-1 to 0.
  - When EN=0, both the counter and `mtime` hold.
- Writes to CTRL clear the prescale counter.
- Bus FSM states:
  - IDLE: if `select & enable & hit`, capture offset, `write` and `wdata`, compute read data, and go to RESP. Otherwise stay in IDLE.
  - RESP: `ready`=1, and `rdata` is the registered read value (0 for writes). A write commits at the clock edge that ends RESP. Always returns to IDLE.
- If `select` drops while the FSM is in RESP, the transfer still completes and commits.
- A transfer is accepted only from IDLE. Back-to-back transfers therefore take 2 cycles each in the access phase.
- Same-cycle conflicts: a bus write to MTIME_LO/HI on a tick edge wins. The written half takes `wdata`, and the other half keeps its pre-tick value with no carry applied.
- Compare rule: `irqTimer` is registered as the unsigned comparison (`mtime >= mtimecmp`), evaluated each cycle on the current register values.

## Timing
- Read/write latency: with the access phase starting at cycle N (in IDLE), `ready`=1 in cycle N+1. `rdata` reflects register state sampled at the end of cycle N.
- Committed write is visible to a read accepted at cycle N+2 or later.
- `irqTimer` lags the comparison by one cycle. After a tick makes `mtime == mtimecmp` at edge E, `irqTimer` rises at edge E+1.
- After a `mtimecmp` write that makes the comparison false, `irqTimer` falls one cycle after the commit edge.
- Asynchronous `rst` mid-transfer forces IDLE and all reset values immediately. `ready` drops without waiting for a clock edge. No partial write is kept.

## Test plan
- Reset, then idle 10 cycles with no bus traffic; then read MTIME_LO:
  - `ready` is 1 for exactly one cycle.
  - `rdata` equals the cycle count since reset release (±1 per the defined sampling point).
  - `irqTimer` stays 0.
- Write CTRL=0x0000_0301 (PRESCALE=3, EN=1):
  - `mtime` increments once every 4 cycles.
  - Write CTRL=0: `mtime` holds across 20 cycles.
- Write MTIME_LO=0xFFFF_FFFE and MTIME_HI=0 with PRESCALE=0. After 2 ticks, read LO then HI: returns 0x0000_0000 / 0x0000_0001, the carry across the 32-bit boundary.
- Set MTIMECMP={0, 0x100} with `mtime`=0xF0:
  - `irqTimer` rises exactly one cycle after `mtime` reaches 0x100.
  - Write MTIMECMP_HI=1: `irqTimer` falls one cycle after the commit.
- Non-hit address 0x5000_0000 read, and a `select` without `enable`: `ready` and `rdata` stay 0. Access to offset 0x3C returns `rdata`=0 with `ready`=1.
- Assert `rst` during RESP of a write to MTIMECMP_LO:
  - `ready` drops immediately.
  - After release, MTIMECMP_LO reads 0xFFFF_FFFF.

Source files
------------

// File: rtl/bus_timer_if.sv
// Bus signals between the core's bus access unit and the machine timer.
// The master drives the transfer; the slave answers with ready and rdata.
interface bus_timer_if;
    logic [31:0] addr;
    logic        select;
    logic        enable;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output addr, select, enable, write, wdata,
        input  rdata, ready
    );

    modport slave (
        input  addr, select, enable, write, wdata,
        output rdata, ready
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: free-running 64-bit mtime with prescaler, mtimecmp and a
// level interrupt. Every accepted transfer takes one response cycle.
module bus_timer #(
    parameter logic [31:0] BaseAddr = 32'h4000_0000
) (
    input  logic       clk,
    input  logic       rst,
    bus_timer_if.slave bus,
    output logic       irqTimer
);
    typedef enum logic {StIdle, StResp} state_e;

    localparam logic [5:0] OffMtimeLo     = 6'h00;
    localparam logic [5:0] OffMtimeHi     = 6'h01;
    localparam logic [5:0] OffCmpLo       = 6'h02;
    localparam logic [5:0] OffCmpHi       = 6'h03;
    localparam logic [5:0] OffCtrl        = 6'h04;
    localparam logic [5:0] OffMtimeHiLive = 6'h05;

    state_e      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] shadow_hi_q, shadow_hi_d;
    logic        en_q, en_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  off_q, off_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic        accept;
    logic        tick;
    logic        commit;
    logic [5:0]  offset;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    always_comb begin
        hit    = bus.addr[31:8] == BaseAddr[31:8];
        offset = bus.addr[7:2];
        accept = (state_q == StIdle) && bus.select && bus.enable && hit;
        tick   = en_q && (cnt_q == prescale_q);
        commit = (state_q == StResp) && wr_q;
        case (offset)
            OffMtimeLo:     rd_val = mtime_q[31:0];
            OffMtimeHi:     rd_val = shadow_hi_q;
            OffCmpLo:       rd_val = mtimecmp_q[31:0];
            OffCmpHi:       rd_val = mtimecmp_q[63:32];
            OffCtrl:        rd_val = {16'h0000, prescale_q, 7'h00, en_q};
            OffMtimeHiLive: rd_val = mtime_q[63:32];
            default:        rd_val = 32'h0000_0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        shadow_hi_d = shadow_hi_q;
        en_d        = en_q;
        prescale_d  = prescale_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        irq_d       = mtime_q >= mtimecmp_q;

        if (en_q) begin
            cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
        end
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StResp;
                    off_d   = offset;
                    wr_d    = bus.write;
                    wdata_d = bus.wdata;
                    rdata_d = bus.write ? 32'h0000_0000 : rd_val;
                    // LO read latches the upper half so a following HI read is coherent.
                    if (!bus.write && (offset == OffMtimeLo)) begin
                        shadow_hi_d = mtime_q[63:32];
                    end
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A bus write overrides a same-edge tick; the untouched half keeps its pre-tick value.
        if (commit) begin
            case (off_q)
                OffMtimeLo: mtime_d = {mtime_q[63:32], wdata_q};
                OffMtimeHi: mtime_d = {wdata_q, mtime_q[31:0]};
                OffCmpLo:   mtimecmp_d = {mtimecmp_q[63:32], wdata_q};
                OffCmpHi:   mtimecmp_d = {wdata_q, mtimecmp_q[31:0]};
                OffCtrl: begin
                    en_d       = wdata_q[0];
                    prescale_d = wdata_q[15:8];
                    cnt_d      = 8'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_hi_q <= 32'd0;
            en_q        <= 1'b1;
            prescale_q  <= 8'd0;
            cnt_q       <= 8'd0;
            off_q       <= 6'd0;
            wr_q        <= 1'b0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            shadow_hi_q <= shadow_hi_d;
            en_q        <= en_d;
            prescale_q  <= prescale_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.ready = (state_q == StResp);
    assign bus.rdata = (state_q == StResp) ? rdata_q : 32'h0000_0000;
    assign irqTimer  = irq_q;
endmodule
